// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the serial arithmetic blocks.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell; the borrow-propagating counterpart of the full adder.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock through a
// single full-subtractor cell, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  import arith_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] p_sr;
  logic [WIDTH-1:0] p_next;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d;
  logic             bout;
  logic             last;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  // Shift-based MSB insert keeps the expression legal when WIDTH is 1.
  assign p_next = (p_sr >> 1) | (WIDTH'(d) << (WIDTH - 1));
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // diff/borrow only change on the final shift edge, so the previous result
  // stays visible while the next operation is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      p_sr   <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            p_sr <= '0;
            cnt  <= '0;
            bin  <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          p_sr <= p_next;
          bin  <= bout;
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff   <= p_next;
            borrow <= bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and scoreboarded checks for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n8, rst_n1;
  logic       start8, start1;
  logic [7:0] a8, b8, diff8;
  logic [0:0] a1, b1, diff1;
  logic       busy8, done8, borrow8;
  logic       busy1, done1, borrow1;

  int asserts  = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n8),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (borrow8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n1),
    .start  (start1),
    .a      (a1),
    .b      (b1),
    .busy   (busy1),
    .done   (done1),
    .diff   (diff1),
    .borrow (borrow1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    asserts++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic s);
    a8     = a;
    b8     = b;
    start8 = s;
  endtask

  // Pulses start for one cycle, waits (bounded) for done, checks latency and result.
  task automatic runOp8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input string tag);
    int n;
    applyStimulus(a, b, 1'b1);
    tick();
    applyStimulus(~a, ~b, 1'b0);
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, " latency"}, n, 8);
    checkOutput({tag, " diff"}, diff8, ed);
    checkOutput({tag, " borrow"}, borrow8, eb);
    tick();
    checkOutput({tag, " done single"}, done8, 0);
  endtask

  task automatic runOp1(input logic a, input logic b, input logic ed, input logic eb,
                        input string tag);
    int n;
    a1     = a;
    b1     = b;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checkOutput({tag, " busy"}, busy1, 1);
    n = 0;
    while (done1 !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkOutput({tag, " latency"}, n, 1);
    checkOutput({tag, " diff"}, diff1, ed);
    checkOutput({tag, " borrow"}, borrow1, eb);
    tick();
  endtask

  initial begin
    int         n;
    int         dones;
    logic [7:0] opa, opb, nxa, nxb;

    rst_n8 = 1'b0;
    rst_n1 = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    applyStimulus(8'h00, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("reset busy8", busy8, 0);
    checkOutput("reset done8", done8, 0);
    checkOutput("reset diff8", diff8, 0);
    checkOutput("reset borrow8", borrow8, 0);
    checkOutput("reset busy1", busy1, 0);
    checkOutput("reset diff1", diff1, 0);
    rst_n8 = 1'b1;
    rst_n1 = 1'b1;
    tick();

    $display("[TB] 0x5A - 0x33 with busy/done timing");
    applyStimulus(8'h5A, 8'h33, 1'b1);
    tick();
    applyStimulus(8'h00, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("busy window %0d", i), {busy8, done8}, 2'b10);
      tick();
    end
    checkOutput("5A-33 done", {busy8, done8}, 2'b01);
    checkOutput("5A-33 diff", diff8, 8'h27);
    checkOutput("5A-33 borrow", borrow8, 0);
    tick();
    checkOutput("5A-33 done drop", done8, 0);
    checkOutput("5A-33 diff hold", diff8, 8'h27);

    runOp8(8'h10, 8'h20, 8'hF0, 1'b1, "10-20");
    runOp8(8'hFF, 8'hFF, 8'h00, 1'b0, "FF-FF");
    runOp8(8'h00, 8'h01, 8'hFF, 1'b1, "00-01");

    $display("[TB] 0x80 - 0x01 with ignored start mid-shift");
    applyStimulus(8'h80, 8'h01, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 1'b0);
    tick();
    tick();
    applyStimulus(8'h00, 8'h00, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("80-01 held diff", diff8, 8'hFF);
    checkOutput("80-01 held borrow", borrow8, 1);
    n = 3;
    while (done8 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("80-01 latency", n, 8);
    checkOutput("80-01 diff", diff8, 8'h7F);
    checkOutput("80-01 borrow", borrow8, 0);
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done8 === 1'b1 || busy8 === 1'b1) dones++;
    end
    checkOutput("80-01 no second op", dones, 0);

    $display("[TB] reset mid-shift");
    applyStimulus(8'h5A, 8'h33, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    rst_n8 = 1'b0;
    tick();
    rst_n8 = 1'b1;
    checkOutput("midreset busy", busy8, 0);
    checkOutput("midreset done", done8, 0);
    checkOutput("midreset diff", diff8, 0);
    checkOutput("midreset borrow", borrow8, 0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 === 1'b1) dones++;
    end
    checkOutput("midreset no done", dones, 0);
    runOp8(8'hC3, 8'h3C, 8'h87, 1'b0, "C3-3C");

    $display("[TB] WIDTH=1 exhaustive");
    runOp1(1'b0, 1'b0, 1'b0, 1'b0, "w1 00");
    runOp1(1'b0, 1'b1, 1'b1, 1'b1, "w1 01");
    runOp1(1'b1, 1'b0, 1'b1, 1'b0, "w1 10");
    runOp1(1'b1, 1'b1, 1'b0, 1'b0, "w1 11");

    $display("[TB] back-to-back with start held high");
    opa = 8'($urandom);
    opb = 8'($urandom);
    applyStimulus(opa, opb, 1'b1);
    tick();
    for (int op = 0; op < 6; op++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'b1);
      dones = 0;
      for (int i = 0; i < 7; i++) begin
        tick();
        if (done8 === 1'b1) dones++;
      end
      tick();
      checkOutput($sformatf("b2b %0d early done", op), dones, 0);
      checkOutput($sformatf("b2b %0d done", op), done8, 1);
      checkOutput($sformatf("b2b %0d diff", op), diff8, 8'(opa - opb));
      checkOutput($sformatf("b2b %0d borrow", op), borrow8, (opa < opb) ? 1 : 0);
      nxa = 8'($urandom);
      nxb = 8'($urandom);
      applyStimulus(nxa, nxb, 1'b1);
      tick();
      checkOutput($sformatf("b2b %0d done drop", op), done8, 0);
      tick();
      opa = nxa;
      opb = nxb;
    end
    applyStimulus(8'h00, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
